booth_alu_seq: RTL and testbench
================================

Name: booth_alu_seq

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational ALU.
- Add/sub complete in one cycle. Multiply is an iterative radix-2 Booth (signed). Divide is an iterative restoring divider (unsigned), with a defined divide-by-zero response.
- A start/busy/done handshake lets a sequencer or register-file datapath issue one operation at a time.
- Produces a double-width result plus zero/carry/overflow/div-by-zero flags.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  2  00 add, 01 sub, 10 mul (signed Booth), 11 div (unsigned).
- a  input  WIDTH  operand A; captured on accept.
- b  input  WIDTH  operand B; captured on accept.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- result_lo  output  WIDTH  sum/difference, product[WIDTH-1:0], or quotient.
- result_hi  output  WIDTH  0 for add/sub, product[2W-1:W], or remainder.
- zero_flag  output  1  {result_hi,result_lo}==0.
- carry_flag  output  1  add: carry-out; sub: borrow (a<b unsigned); else 0.
- ovf_flag  output  1  add/sub: signed overflow; else 0.
- dbz_flag  output  1  div with b==0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM to IDLE.
  - busy, done, result_lo, result_hi and all flags go to 0.
  - Operand/accumulator registers are cleared.
- Reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 accepts the request and latches a, b and op.
  - add, sub, or div with b==0 -> FIN.
  - mul, or div with b!=0 -> RUN, with busy=1 and counter=WIDTH.
- RUN:
  - One iteration per cycle; counter decrements. When the counter reaches 1 the iteration completes and the FSM goes to FIN.
  - Mul: Booth pair {Q0,Q-1}: 01 -> A+=M; 10 -> A-=M; then arithmetic right shift of {A,Q,Q-1}.
  - Div: shift {R,Q} left; trial R-B; if non-negative keep it and set Q0=1, else restore and set Q0=0.
- FIN:
  - Register the outputs and flags; done=1 for this cycle only; busy=0.
  - Return to IDLE.
  - FIN is also the cycle after RUN's final iteration.
- Latency, accept edge to done high:
  - add/sub/dbz: 1 cycle.
  - mul/div: WIDTH+1 cycles.
- Back-to-back throughput: start may be re-asserted in the cycle done is high. It is sampled only in IDLE, so the next accept happens on the following edge.
- start while busy=1 (including RUN) is ignored; operands are not re-latched.
- Result hold: result_lo/result_hi and flags hold their last values until the next done. They do not change while busy.
- Arithmetic rules:
  - Add/sub wrap modulo 2^WIDTH.
  - ovf for add: sign(a)==sign(b) and sign(sum)!=sign(a).
  - ovf for sub: sign(a)!=sign(b) and sign(diff)!=sign(a).
  - Mul: full 2*WIDTH two's-complement product. The most-negative × most-negative case must be exact (0x80*0x80 = 16'h4000 at WIDTH=8).
  - Div: a, b unsigned; quotient = floor(a/b); remainder = a mod b.
- Divide by zero:
  - dbz_flag=1, result_lo = all ones, result_hi = a.
  - zero_flag is computed normally; carry and ovf are 0.
- Flags not applicable to an op are driven 0 at done.

Test Plan (WIDTH=8):
- Reset check: hold rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, then add a=200, b=100 -> done 1 cycle after accept; lo=0x2C, hi=0, carry=1, ovf=0.
- Sub a=0x80, b=0x01 -> lo=0x7F, ovf=1, carry=0. Then sub a=5, b=5 -> lo=0, zero_flag=1.
- Signed mul:
  - a=0xFD (-3), b=0x05 -> done exactly 9 cycles after accept; {hi,lo}=16'hFFF1.
  - a=0x80, b=0x80 -> 16'h4000.
  - a=0, b=0x7F -> zero_flag=1.
- Div a=100, b=7 -> done at 9 cycles; lo=14, hi=2. Div a=0xF0, b=0 -> done at 1 cycle; dbz=1, lo=0xFF, hi=0xF0.
- Handshake:
  - Pulse start with mul, then re-pulse start with add at cycle 3 -> ignored; the mul result is unchanged.
  - Assert start for a new op in the done cycle -> accepted on the next edge.
  - A 2nd done never occurs without a new accept.
- Abort: start div, assert rst_n=0 at cycle 4 -> busy=0 and no done pulse. After release, a fresh div 9/3 -> lo=3, hi=0.

Source files
------------

// File: rtl/booth_alu_if.sv
// Request/response bundle between an issuing sequencer (master) and booth_alu_seq (slave).
interface booth_alu_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             zero_flag;
   logic             carry_flag;
   logic             ovf_flag;
   logic             dbz_flag;

   modport master (
      output start, op, a, b,
      input  busy, done, result_lo, result_hi, zero_flag, carry_flag, ovf_flag, dbz_flag
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result_lo, result_hi, zero_flag, carry_flag, ovf_flag, dbz_flag
   );
endinterface

// File: rtl/booth_alu_seq.sv
// Multi-cycle ALU: single-pass add/sub, iterative radix-2 signed Booth multiply and
// unsigned restoring divide, with a start/busy/done handshake and registered results.
module booth_alu_seq #(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst_n,
   booth_alu_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_nxt;

   logic [1:0]              op_r;
   logic [WIDTH-1:0]        a_r, b_r;
   logic signed [WIDTH:0]   acc, acc_nxt;
   logic [WIDTH-1:0]        q_r, q_nxt;
   logic                    qm1, qm1_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic                    accept;
   logic [WIDTH:0]          sum_ext, dif_ext;
   logic [WIDTH-1:0]        res_lo, res_hi;
   logic                    res_c, res_v, res_d;

   function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   // Accumulator is one bit wider than the operands so that subtracting the most
   // negative multiplicand cannot overflow; returns the shifted {A, Q, Q-1}.
   function automatic logic [2*WIDTH+1:0] booth_step(input logic signed [WIDTH:0] acc_i,
                                                     input logic signed [WIDTH:0] m_i,
                                                     input logic [WIDTH-1:0]      q_i,
                                                     input logic                  qm1_i);
      logic signed [WIDTH:0] s;
      case ({q_i[0], qm1_i})
         2'b01:   s = acc_i + m_i;
         2'b10:   s = acc_i - m_i;
         default: s = acc_i;
      endcase
      return {s[WIDTH], s, q_i};
   endfunction

   function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   r_i,
                                                 input logic [WIDTH-1:0] q_i,
                                                 input logic [WIDTH-1:0] d_i);
      logic [WIDTH:0] r_sh, t;
      r_sh = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
      t    = r_sh - {1'b0, d_i};
      if (!t[WIDTH]) return {t, q_i[WIDTH-2:0], 1'b1};
      else           return {r_sh, q_i[WIDTH-2:0], 1'b0};
   endfunction

   assign accept = (state == IDLE) && bus.start;

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      q_nxt     = q_r;
      qm1_nxt   = qm1;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0)) begin
                  state_nxt = RUN;
                  cnt_nxt   = CNT_W'(WIDTH);
                  acc_nxt   = '0;
                  qm1_nxt   = 1'b0;
                  q_nxt     = (bus.op == OP_MUL) ? bus.b : bus.a;
               end else begin
                  state_nxt = FIN;
               end
            end
         end
         RUN: begin
            if (op_r == OP_MUL)
               {acc_nxt, q_nxt, qm1_nxt} = booth_step(acc, $signed({a_r[WIDTH-1], a_r}), q_r, qm1);
            else
               {acc_nxt, q_nxt} = div_step(acc, q_r, b_r);
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = FIN;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result selection, consumed only on the FIN edge.
   always_comb begin
      res_lo  = '0;
      res_hi  = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_d   = 1'b0;
      sum_ext = {1'b0, a_r} + {1'b0, b_r};
      dif_ext = {1'b0, a_r} - {1'b0, b_r};
      case (op_r)
         OP_ADD: begin
            res_lo = sum_ext[WIDTH-1:0];
            res_c  = sum_ext[WIDTH];
            res_v  = ovf_add(a_r[WIDTH-1], b_r[WIDTH-1], sum_ext[WIDTH-1]);
         end
         OP_SUB: begin
            res_lo = dif_ext[WIDTH-1:0];
            res_c  = dif_ext[WIDTH];
            res_v  = ovf_sub(a_r[WIDTH-1], b_r[WIDTH-1], dif_ext[WIDTH-1]);
         end
         OP_MUL: begin
            res_lo = q_r;
            res_hi = acc[WIDTH-1:0];
         end
         default: begin
            if (b_r == '0) begin
               res_lo = '1;
               res_hi = a_r;
               res_d  = 1'b1;
            end else begin
               res_lo = q_r;
               res_hi = acc[WIDTH-1:0];
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         q_r   <= '0;
         qm1   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         q_r   <= q_nxt;
         qm1   <= qm1_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r           <= '0;
         a_r            <= '0;
         b_r            <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.result_lo  <= '0;
         bus.result_hi  <= '0;
         bus.zero_flag  <= 1'b0;
         bus.carry_flag <= 1'b0;
         bus.ovf_flag   <= 1'b0;
         bus.dbz_flag   <= 1'b0;
      end else begin
         if (accept) begin
            op_r <= bus.op;
            a_r  <= bus.a;
            b_r  <= bus.b;
         end
         if (accept)             bus.busy <= 1'b1;
         else if (state == FIN)  bus.busy <= 1'b0;
         bus.done <= (state == FIN);
         if (state == FIN) begin
            bus.result_lo  <= res_lo;
            bus.result_hi  <= res_hi;
            bus.zero_flag  <= (res_lo == '0) && (res_hi == '0);
            bus.carry_flag <= res_c;
            bus.ovf_flag   <= res_v;
            bus.dbz_flag   <= res_d;
         end
      end
   end
endmodule

// File: tb/tb_booth_alu_seq.sv
// Directed scoreboard bench for booth_alu_seq at WIDTH=8.
module tb_booth_alu_seq;
   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   booth_alu_if #(.WIDTH(W)) bus ();

   booth_alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         z, c, v, d;
      int           lat;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   total = 0;
   int   bad = 0;
   int   exp_dones = 0;
   int   acc_cyc = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   s;
      int   p;
      e.lo = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.d = 1'b0; e.lat = 1;
      case (op)
         2'b00: begin
            s    = int'(a) + int'(b);
            e.lo = s[W-1:0];
            e.c  = (s > (1 << W) - 1);
            s    = int'($signed(a)) + int'($signed(b));
            e.v  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
         end
         2'b01: begin
            e.lo = a - b;
            e.c  = (a < b);
            s    = int'($signed(a)) - int'($signed(b));
            e.v  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
         end
         2'b10: begin
            p             = int'($signed(a)) * int'($signed(b));
            {e.hi, e.lo}  = p[2*W-1:0];
            e.lat         = W + 1;
         end
         default: begin
            if (b == '0) begin
               e.lo = '1; e.hi = a; e.d = 1'b1;
            end else begin
               e.lo = a / b; e.hi = a % b; e.lat = W + 1;
            end
         end
      endcase
      e.z = ({e.hi, e.lo} == '0);
      return e;
   endfunction

   function automatic logic [31:0] outs();
      return 32'({bus.busy, bus.done, bus.zero_flag, bus.carry_flag, bus.ovf_flag,
                  bus.dbz_flag, bus.result_hi, bus.result_lo});
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      if (push) begin
         sb.push_back(model(op, a, b));
         exp_dones++;
      end
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit   got;
      exp_t e;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check({tag, "_done"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_lat"},  32'(cyc - acc_cyc), 32'(e.lat));
            check({tag, "_lo"},   32'(bus.result_lo), 32'(e.lo));
            check({tag, "_hi"},   32'(bus.result_hi), 32'(e.hi));
            check({tag, "_flags"}, 32'({bus.zero_flag, bus.carry_flag, bus.ovf_flag, bus.dbz_flag}),
                  32'({e.z, e.c, e.v, e.d}));
            check({tag, "_busy"}, 32'(bus.busy), 32'd0);
            last = e;
         end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("reset_state", outs(), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk); issue(2'b00, 8'd200, 8'd100, 1'b1); wait_done("add_200_100");
      @(negedge clk); issue(2'b01, 8'h80, 8'h01, 1'b1);   wait_done("sub_80_01");
      @(negedge clk); issue(2'b01, 8'd5, 8'd5, 1'b1);     wait_done("sub_5_5");
      @(negedge clk); issue(2'b10, 8'hFD, 8'h05, 1'b1);   wait_done("mul_m3_5");

      // Asynchronous reset in the middle of the low phase must clear outputs at once.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset", outs(), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk); issue(2'b10, 8'h80, 8'h80, 1'b1);   wait_done("mul_80_80");
      @(negedge clk); issue(2'b10, 8'h00, 8'h7F, 1'b1);   wait_done("mul_0_7f");
      @(negedge clk); issue(2'b11, 8'd100, 8'd7, 1'b1);   wait_done("div_100_7");
      @(negedge clk); issue(2'b11, 8'hF0, 8'h00, 1'b1);   wait_done("div_by_zero");

      // Start during RUN is ignored and results hold while busy.
      @(negedge clk); issue(2'b10, 8'd7, 8'hFE, 1'b1);
      check("hold_busy", 32'(bus.busy), 32'd1);
      check("hold_lo", 32'(bus.result_lo), 32'(last.lo));
      @(posedge clk); #1;
      @(posedge clk);
      @(negedge clk);
      bus.op = 2'b00; bus.a = 8'd1; bus.b = 8'd1; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done("mul_ignore");
      repeat (4) @(posedge clk);
      #1 check("no_extra_done", 32'(done_cnt), 32'(exp_dones));
      check("result_held", 32'({bus.result_hi, bus.result_lo}), 32'({last.hi, last.lo}));

      // Start raised in the done cycle is accepted on the next edge.
      @(negedge clk); issue(2'b01, 8'd5, 8'd5, 1'b1); wait_done("sub_b2b");
      issue(2'b00, 8'd3, 8'd4, 1'b1);                  wait_done("add_b2b");

      // Reset mid-divide aborts with no done.
      @(negedge clk); issue(2'b11, 8'd200, 8'd3, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("abort_outputs", outs(), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1 check("abort_no_done", 32'(done_cnt), 32'(exp_dones));
      @(negedge clk); issue(2'b11, 8'd9, 8'd3, 1'b1);   wait_done("div_9_3");

      repeat (3) @(posedge clk);
      #1 check("done_count", 32'(done_cnt), 32'(exp_dones));
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
